// File: rtl/PixelSensorConfig.sv
// Shared configuration for the pixel sensor: array geometry, ADC width and
// the frame sequencer state encoding.
package PixelSensorConfig;
  localparam int PIXEL_BITS        = 8;
  localparam int PIXEL_ARRAY_WIDTH = 2;
  localparam int C_ERASE           = 5;

  typedef enum logic [2:0] {
    IDLE, ERASE, GAP1, EXPOSE, GAP2, CONVERT, GAP3, READ
  } frame_state_t;
endpackage

// File: rtl/pixel_readout_seq.sv
// Row readout sequencer: presents rows 0..NUM_ROWS-1 one at a time on a
// valid/ready handshake and flags the transfer of the final row.
module pixel_readout_seq #(
  parameter int NUM_ROWS = 2,
  parameter int IDX_W    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                launch,
  input  logic                row_ready,
  output logic [NUM_ROWS-1:0] row_sel,
  output logic [IDX_W-1:0]    row_idx,
  output logic                row_valid,
  output logic                done
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

  logic             last_row;
  logic             xfer;
  logic [IDX_W-1:0] idx_inc;

  assign xfer    = row_valid && row_ready;
  assign idx_inc = row_idx + IDX_W'(1);
  // Combinational on row_ready: the pulse must land in the transfer cycle itself.
  assign done    = xfer && last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_sel   <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      last_row  <= 1'b0;
    end else if (launch) begin
      row_sel   <= NUM_ROWS'(1);
      row_idx   <= '0;
      row_valid <= 1'b1;
      last_row  <= (NUM_ROWS == 1);
    end else if (xfer) begin
      if (last_row) begin
        row_sel   <= '0;
        row_idx   <= '0;
        row_valid <= 1'b0;
        last_row  <= 1'b0;
      end else begin
        row_sel  <= row_sel << 1;
        row_idx  <= idx_inc;
        last_row <= (idx_inc == LAST_IDX);
      end
    end
  end
endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, convert (with ADC ramp)
// and row readout, in single-shot or continuous mode.
module pixel_frame_ctrl #(
  parameter int  NUM_ROWS    = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int  PIXEL_BITS  = PixelSensorConfig::PIXEL_BITS,
  parameter int  C_ERASE     = PixelSensorConfig::C_ERASE,
  parameter int  EXPOSE_BITS = 8,
  localparam int IDX_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [EXPOSE_BITS-1:0] expose_cycles,
  output logic                   erase,
  output logic                   expose,
  output logic                   convert,
  output logic [PIXEL_BITS-1:0]  adc_counter,
  output logic [NUM_ROWS-1:0]    row_sel,
  output logic [IDX_W-1:0]       row_idx,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic                   busy,
  output logic                   frame_done
);
  import PixelSensorConfig::*;

  localparam int ERASE_W = (C_ERASE > 1) ? $clog2(C_ERASE) : 1;
  localparam int CNT_W   = (EXPOSE_BITS > ERASE_W) ? EXPOSE_BITS : ERASE_W;
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(C_ERASE - 1);

  frame_state_t            state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [EXPOSE_BITS-1:0]  exp_lat, exp_lat_n;
  logic [PIXEL_BITS-1:0]   adc_n;
  logic [CNT_W-1:0]        expose_load;
  logic                    launch;
  logic                    rd_done;

  // Phase counter counts down to 0; a zero exposure still gets one cycle.
  assign expose_load = (exp_lat == '0) ? '0 : CNT_W'(exp_lat - EXPOSE_BITS'(1));
  assign launch      = (state == GAP3);
  assign frame_done  = rd_done;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    exp_lat_n = exp_lat;
    adc_n     = '0;
    case (state)
      IDLE: if (start) begin
        state_n   = ERASE;
        cnt_n     = ERASE_LOAD;
        exp_lat_n = expose_cycles;
      end
      ERASE: if (cnt == '0) state_n = GAP1;
             else           cnt_n   = cnt - CNT_W'(1);
      GAP1: begin
        state_n = EXPOSE;
        cnt_n   = expose_load;
      end
      EXPOSE: if (cnt == '0) state_n = GAP2;
              else           cnt_n   = cnt - CNT_W'(1);
      GAP2:    state_n = CONVERT;
      // The ramp doubles as the convert-phase timer; it stops at full scale.
      CONVERT: if (adc_counter == '1) state_n = GAP3;
               else                   adc_n   = adc_counter + PIXEL_BITS'(1);
      GAP3:    state_n = READ;
      READ: if (rd_done) begin
        if (continuous) begin
          state_n   = ERASE;
          cnt_n     = ERASE_LOAD;
          exp_lat_n = expose_cycles;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      exp_lat     <= '0;
      adc_counter <= '0;
      erase       <= 1'b0;
      expose      <= 1'b0;
      convert     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      exp_lat     <= exp_lat_n;
      adc_counter <= adc_n;
      erase       <= (state_n == ERASE);
      expose      <= (state_n == EXPOSE);
      convert     <= (state_n == CONVERT);
      busy        <= (state_n != IDLE);
    end
  end

  pixel_readout_seq #(
    .NUM_ROWS (NUM_ROWS),
    .IDX_W    (IDX_W)
  ) u_readout (
    .clk       (clk),
    .reset     (reset),
    .launch    (launch),
    .row_ready (row_ready),
    .row_sel   (row_sel),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .done      (rd_done)
  );
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Scoreboard bench for pixel_frame_ctrl: stimulus queues expected phase and
// row events, a negedge monitor pops and compares them as they appear.
module tb_pixel_frame_ctrl;
  localparam int NR = 4, PB = 8, CE = 5, EB = 8, IW = 2, CONV = 256;

  logic          clk = 1'b0;
  logic          reset, start, continuous, row_ready;
  logic [EB-1:0] expose_cycles;
  logic          erase, expose, convert, row_valid, busy, frame_done;
  logic [PB-1:0] adc_counter;
  logic [NR-1:0] row_sel;
  logic [IW-1:0] row_idx;

  pixel_frame_ctrl #(
    .NUM_ROWS(NR), .PIXEL_BITS(PB), .C_ERASE(CE), .EXPOSE_BITS(EB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_cycles(expose_cycles), .erase(erase), .expose(expose),
    .convert(convert), .adc_counter(adc_counter), .row_sel(row_sel),
    .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef enum int {
    EV_ERASE_OFF, EV_EXPOSE_OFF, EV_CONV_OFF,
    EV_ERASE_ON, EV_EXPOSE_ON, EV_CONV_ON,
    EV_XFER, EV_DONE, EV_IDLE
  } ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0, errors = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input logic [31:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s at cycle %0d val %0h, expected no event", k.name(), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val !== v) begin
        errors++;
        $display("FAIL event: got %s cyc %0d val %0h, expected %s cyc %0d val %0h",
                 k.name(), cyc, v, e.kind.name(), e.cyc, e.val);
      end
    end
  endtask

  // Expected events of one frame started at edge t0 with n expose cycles;
  // row srow and later are delayed by slen stall cycles.
  task automatic push_frame(input int t0, input int n, input int srow, input int slen,
                            input bit idle_after, output int done_c);
    int x0, c;
    x0 = t0 + CE + 4 + n + CONV;
    push(EV_ERASE_ON,   t0 + 1,               0);
    push(EV_ERASE_OFF,  t0 + CE + 1,          0);
    push(EV_EXPOSE_ON,  t0 + CE + 2,          0);
    push(EV_EXPOSE_OFF, t0 + CE + 2 + n,      0);
    push(EV_CONV_ON,    t0 + CE + 3 + n,      0);
    push(EV_CONV_OFF,   t0 + CE + 3 + n + CONV, CONV - 1);
    c = x0;
    for (int r = 0; r < NR; r++) begin
      c = x0 + r + ((r >= srow) ? slen : 0);
      push(EV_XFER, c, (r << NR) | (1 << r));
    end
    done_c = c;
    push(EV_DONE, done_c, NR - 1);
    if (idle_after) push(EV_IDLE, done_c + 1, 0);
  endtask

  // Monitor: samples mid-cycle, after stimulus has settled.
  logic          p_erase = 0, p_expose = 0, p_conv = 0, p_valid = 0, p_ready = 0, p_busy = 0;
  logic [PB-1:0] p_adc = '0;
  logic [NR-1:0] p_sel = '0;
  logic [IW-1:0] p_idx = '0;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("strobe_exclusive", 32'($countones({erase, expose, convert, row_valid}) <= 1), 1);
      if (!convert)   chk("adc_zero_outside_convert", adc_counter, 0);
      else if (p_conv) chk("adc_ramp_step", adc_counter, p_adc + 1);
      if (p_valid && !p_ready)
        chk("stall_hold", {row_valid, row_idx, row_sel}, {1'b1, p_idx, p_sel});
      if (p_erase && !erase)   got(EV_ERASE_OFF, 0);
      if (p_expose && !expose) got(EV_EXPOSE_OFF, 0);
      if (p_conv && !convert)  got(EV_CONV_OFF, p_adc);
      if (!p_erase && erase)   got(EV_ERASE_ON, 0);
      if (!p_expose && expose) got(EV_EXPOSE_ON, 0);
      if (!p_conv && convert)  got(EV_CONV_ON, adc_counter);
      if (row_valid && row_ready) got(EV_XFER, {row_idx, row_sel});
      if (frame_done) got(EV_DONE, row_idx);
      if (p_busy && !busy)
        got(EV_IDLE, {erase, expose, convert, adc_counter, row_sel, row_idx, row_valid, frame_done});
    end
    p_erase  <= erase;    p_expose <= expose;   p_conv  <= convert;
    p_valid  <= row_valid; p_ready <= row_ready; p_busy <= busy;
    p_adc    <= adc_counter; p_sel <= row_sel;  p_idx   <= row_idx;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic kick(input int n, input bit cont, output int t0);
    t0 = cyc;
    start = 1'b1;
    expose_cycles = EB'(n);
    continuous = cont;
  endtask

  int t0, d, d2;

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; row_ready = 1'b1; expose_cycles = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_state",
        {erase, expose, convert, adc_counter, row_sel, row_idx, row_valid, frame_done, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, exposure 10, no stalls.
    kick(10, 1'b0, t0);
    push_frame(t0, 10, NR, 0, 1'b1, d);
    @(negedge clk); start = 1'b0;
    wait_until(d + 3);

    // Backpressure: row 2 stalled for 3 cycles.
    kick(10, 1'b0, t0);
    push_frame(t0, 10, 2, 3, 1'b1, d);
    @(negedge clk); start = 1'b0;
    wait_until(t0 + 277); row_ready = 1'b0;
    wait_until(t0 + 280); row_ready = 1'b1;
    wait_until(d + 3);

    // Zero exposure, plus start/expose changes while busy.
    kick(0, 1'b0, t0);
    push_frame(t0, 1, NR, 0, 1'b1, d);
    @(negedge clk); start = 1'b0;
    wait_until(t0 + 3);   start = 1'b1; expose_cycles = 8'd50;
    @(negedge clk);       start = 1'b0;
    wait_until(t0 + 200); start = 1'b1;
    @(negedge clk);       start = 1'b0;
    wait_until(d);        start = 1'b1;
    @(negedge clk);       start = 1'b0;
    wait_until(d + 3);

    // Continuous: frame 1 exposes 10, frame 2 picks up 3, then stops.
    kick(10, 1'b1, t0);
    push_frame(t0, 10, NR, 0, 1'b0, d);
    push_frame(d, 3, NR, 0, 1'b1, d2);
    @(negedge clk); start = 1'b0;
    wait_until(t0 + 3);   expose_cycles = 8'd3;
    wait_until(t0 + 100); continuous = 1'b0;
    wait_until(t0 + 200); continuous = 1'b1;
    wait_until(d + 50);   continuous = 1'b0;
    wait_until(d2 + 3);

    // Reset in CONVERT at adc_counter=100, then a clean full frame.
    kick(10, 1'b0, t0);
    push(EV_ERASE_ON,   t0 + 1,  0);
    push(EV_ERASE_OFF,  t0 + 6,  0);
    push(EV_EXPOSE_ON,  t0 + 7,  0);
    push(EV_EXPOSE_OFF, t0 + 17, 0);
    push(EV_CONV_ON,    t0 + 18, 0);
    push(EV_CONV_OFF,   t0 + 119, 100);
    push(EV_IDLE,       t0 + 119, 0);
    @(negedge clk); start = 1'b0;
    wait_until(t0 + 118); reset = 1'b1;
    wait_until(t0 + 119); reset = 1'b0;
    wait_until(t0 + 122);
    kick(10, 1'b0, t0);
    push_frame(t0, 10, NR, 0, 1'b1, d);
    @(negedge clk); start = 1'b0;
    wait_until(d + 3);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    chk("events_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
